// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Shared UART constants and the arbiter FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Explicit 3-bit state codes, kept as plain constants so other blocks can reuse them
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_BUSY  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_GRANT = S_GRANT,
    ST_START = S_START,
    ST_ACK   = S_ACK,
    ST_BUSY  = S_BUSY
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Returns the first set
//                request bit at or after the pointer, wrapping modulo N.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx,
  output logic [N-1:0]  o_onehot
);

  int w_pos;

  // Scan offsets from farthest to nearest so the nearest set bit is written last and wins
  always_comb begin
    o_valid  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    w_pos    = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_pos = int'(i_ptr) + i;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      if (i_req[IW'(w_pos)]) begin
        o_valid  = 1'b1;
        o_idx    = IW'(w_pos);
        o_onehot = N'(1) << w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin sharing of one UART_Tx between NUM_REQ byte
//                sources. Grants, latches the byte, pulses start, tracks the
//                transmitter's waitflg and returns a per-source done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [UART_DATA_W*NUM_REQ-1:0] data_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           err_o,
  output logic                           busy_o,
  output logic [UART_DATA_W-1:0]         tx_data_o,
  output logic                           tx_start_o,
  input  logic                           tx_waitflg_i
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  arb_state_e             r_state;
  arb_state_e             w_next;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       r_owner;
  logic [NUM_REQ-1:0]     r_owner_oh;
  logic [UART_DATA_W-1:0] r_data;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_pick_valid;
  logic [PTR_W-1:0]       w_pick_idx;
  logic [NUM_REQ-1:0]     w_pick_onehot;
  logic [UART_DATA_W-1:0] w_bytes [NUM_REQ];

  // Split the flat data bus into one byte per source
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_bytes[g] = data_i[g*UART_DATA_W +: UART_DATA_W];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (PTR_W)
  ) u_pick (
    .i_req    (req_i),
    .i_ptr    (r_ptr),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_onehot)
  );

  assign tx_data_o = r_data;

  // State register; reset aborts any frame in flight without a done pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and pulse outputs; a timeout and a normal finish both end through done_o
  always_comb begin
    w_next     = r_state;
    grant_o    = '0;
    done_o     = '0;
    err_o      = 1'b0;
    tx_start_o = 1'b0;
    busy_o     = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        // An external frame still on the line blocks any new grant
        if (w_pick_valid && !tx_waitflg_i) begin
          w_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        grant_o = r_owner_oh;
        w_next  = ST_START;
      end
      ST_START: begin
        tx_start_o = 1'b1;
        w_next     = ST_ACK;
      end
      ST_ACK: begin
        if (tx_waitflg_i) begin
          w_next = ST_BUSY;
        end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_o  = 1'b1;
          done_o = r_owner_oh;
          w_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!tx_waitflg_i) begin
          done_o = r_owner_oh;
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Owner, byte, round-robin pointer and acknowledge-timeout counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_owner_oh <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_next == ST_GRANT) begin
            r_owner    <= w_pick_idx;
            r_owner_oh <= w_pick_onehot;
          end
        end
        ST_GRANT: begin
          r_data <= w_bytes[r_owner];
          if (r_owner == PTR_W'(NUM_REQ - 1)) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= r_owner + 1'b1;
          end
        end
        ST_START: begin
          r_cnt <= '0;
        end
        ST_ACK: begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
